// File: rtl/flag_register.sv
// Architectural flag register with an interrupt save/restore LIFO and condition evaluation.
// Flags and stack update one cycle after a write; condition and full/empty decode are combinational.
module flag_register #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] set_flags,
  input  logic       set_we,
  input  logic [3:0] alu_flags,
  input  logic       alu_we,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  input  logic [2:0] cond,
  output logic [3:0] flags,
  output logic       cond_true,
  output logic [3:0] depth,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam int         IW         = $clog2(STACK_DEPTH);
  localparam logic [3:0] FULL_DEPTH = 4'(STACK_DEPTH);

  logic [3:0]    flags_q, flags_d;
  logic [3:0]    depth_q, depth_d;
  logic          err_q, err_d;
  logic [3:0]    stack_q [STACK_DEPTH];
  logic [IW-1:0] wr_idx, rd_idx;
  logic          push_ok, pop_ok, err_new;

  assign stack_full  = (depth_q == FULL_DEPTH);
  assign stack_empty = (depth_q == 4'd0);

  // Depth is a power of two, so the low bits wrap correctly when the stack is full.
  assign wr_idx = depth_q[IW-1:0];
  assign rd_idx = wr_idx - IW'(1);

  always_comb begin
    push_ok = push & ~pop & ~stack_full;
    pop_ok  = pop & ~push & ~stack_empty;
    err_new = (push & ~pop & stack_full) | (pop & ~push & stack_empty);

    flags_d = flags_q;
    if (pop_ok)      flags_d = stack_q[rd_idx];
    else if (alu_we) flags_d = alu_flags;
    else if (set_we) flags_d = set_flags;

    depth_d = depth_q;
    if (push_ok)     depth_d = depth_q + 4'd1;
    else if (pop_ok) depth_d = depth_q - 4'd1;

    // A new error outranks a coincident clear.
    err_d = err_new | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'd0;
      depth_q <= 4'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 4'd0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      if (push_ok) stack_q[wr_idx] <= flags_q;
    end
  end

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = flags_q[0];
      3'd2: cond_true = ~flags_q[0];
      3'd3: cond_true = flags_q[2];
      3'd4: cond_true = ~flags_q[2];
      3'd5: cond_true = flags_q[3];
      3'd6: cond_true = flags_q[1];
      3'd7: cond_true = flags_q[3] ^ flags_q[1];
      default: cond_true = 1'b1;
    endcase
  end

  assign flags     = flags_q;
  assign depth     = depth_q;
  assign stack_err = err_q;

endmodule
